// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator and channel bus sequencer
module voice_allocator #(
    parameter int NUM_CHANNELS = 4,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_STRIDE  = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    note_valid_i,
    output logic                    note_ready_o,
    input  logic                    note_on_i,
    input  logic [6:0]              note_key_i,
    input  logic [7:0]              note_incr_i,
    output logic [15:0]             bus_address_o,
    output logic [7:0]              bus_data_out_o,
    output logic                    bus_read_write_o,
    output logic                    bus_clock_o,
    output logic [NUM_CHANNELS-1:0] active_mask_o,
    output logic                    steal_pulse_o
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
        S_GAP
    } state_e;

    // Which write of a sequence is on the bus: gate-off, increment, gate-on.
    typedef enum logic [1:0] {
        OP_REL,
        OP_INCR,
        OP_GATE
    } op_e;

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic [GW-1:0] gap_q, gap_d;

    // Voice table: key per channel, sounding flags, LRU ranks (0 = most recent).
    logic [6:0]              key_q  [NUM_CHANNELS];
    logic [CW-1:0]           rank_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] active_q;

    // Event and allocation decision latched on transfer.
    logic          ev_on_q;
    logic [6:0]    ev_key_q;
    logic [7:0]    ev_incr_q;
    logic [CW-1:0] ch_q;
    logic          rel_q;
    logic          start_q;

    // Registered outputs.
    logic        ready_q, ready_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        rw_q, rw_d;
    logic        bclk_q, bclk_d;
    logic        steal_q, steal_d;

    logic          transfer;
    logic          hit;
    logic [CW-1:0] hit_idx;
    logic          free_any;
    logic [CW-1:0] free_idx;
    logic [CW-1:0] lru_idx;
    logic [CW-1:0] pick_ch;
    logic          pick_rel;
    logic          pick_start;
    logic          pick_steal;
    logic [15:0]   ch_base;

    assign transfer = note_valid_i & ready_q;
    assign ch_base  = 16'(BASE_ADDR) + 16'(ch_q) * 16'(ADDR_STRIDE);

    // Table search on the incoming key; descending scan leaves the lowest index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        lru_idx  = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (active_q[i] && (key_q[i] == note_key_i)) begin
                hit     = 1'b1;
                hit_idx = CW'(i);
            end
            if (!active_q[i]) begin
                free_any = 1'b1;
                free_idx = CW'(i);
            end
            if (rank_q[i] == CW'(NUM_CHANNELS - 1)) begin
                lru_idx = CW'(i);
            end
        end
    end

    // Allocation policy: retrigger on key match, else free voice, else steal the LRU voice.
    always_comb begin
        pick_ch    = hit_idx;
        pick_rel   = 1'b0;
        pick_start = 1'b0;
        pick_steal = 1'b0;
        if (note_on_i) begin
            pick_start = 1'b1;
            if (hit) begin
                pick_ch  = hit_idx;
                pick_rel = 1'b1;
            end else if (free_any) begin
                pick_ch = free_idx;
            end else begin
                pick_ch    = lru_idx;
                pick_rel   = 1'b1;
                pick_steal = 1'b1;
            end
        end else if (hit) begin
            pick_rel = 1'b1;
        end
    end

    // Capture the event and its allocation decision on the accepting edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ev_on_q   <= 1'b0;
            ev_key_q  <= '0;
            ev_incr_q <= '0;
            ch_q      <= '0;
            rel_q     <= 1'b0;
            start_q   <= 1'b0;
        end else if (transfer) begin
            ev_on_q   <= note_on_i;
            ev_key_q  <= note_key_i;
            ev_incr_q <= note_incr_i;
            ch_q      <= pick_ch;
            rel_q     <= pick_rel;
            start_q   <= pick_start;
        end
    end

    // Voice table and LRU ranks are updated once per event, during LOOKUP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                key_q[i]  <= '0;
                rank_q[i] <= CW'(i);
            end
        end else if (state_q == S_LOOKUP) begin
            if (ev_on_q) begin
                active_q[ch_q] <= 1'b1;
                key_q[ch_q]    <= ev_key_q;
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (CW'(i) == ch_q) begin
                        rank_q[i] <= '0;
                    end else if (rank_q[i] < rank_q[ch_q]) begin
                        rank_q[i] <= rank_q[i] + CW'(1);
                    end
                end
            end else if (rel_q) begin
                active_q[ch_q] <= 1'b0;
            end
        end
    end

    // Sequencer next state: release, optional gap, then increment and gate writes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (rel_q) begin
                    state_d = S_WR_SETUP;
                    op_d    = OP_REL;
                end else if (start_q) begin
                    state_d = S_WR_SETUP;
                    op_d    = OP_INCR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_SETUP:  state_d = S_WR_STROBE;
            S_WR_STROBE: state_d = S_WR_HOLD;
            S_WR_HOLD: begin
                case (op_q)
                    OP_REL: begin
                        if (start_q) begin
                            state_d = S_GAP;
                            gap_d   = GW'(GAP_CYCLES - 1);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    OP_INCR: begin
                        state_d = S_WR_SETUP;
                        op_d    = OP_GATE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_WR_SETUP;
                    op_d    = OP_INCR;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values derived from the next state so every output is a flop.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        rw_d    = (state_d inside {S_WR_SETUP, S_WR_STROBE, S_WR_HOLD});
        bclk_d  = (state_d == S_WR_STROBE);
        steal_d = transfer & pick_steal;
        addr_d  = addr_q;
        data_d  = data_q;
        if (state_d == S_WR_SETUP) begin
            addr_d = ch_base + ((op_d == OP_INCR) ? 16'd1 : 16'd0);
            case (op_d)
                OP_INCR: data_d = ev_incr_q;
                OP_GATE: data_d = 8'h01;
                default: data_d = 8'h00;
            endcase
        end
    end

    // State and output registers; reset aborts any write with the strobe low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= OP_REL;
            gap_q   <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            bclk_q  <= 1'b0;
            steal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            bclk_q  <= bclk_d;
            steal_q <= steal_d;
        end
    end

    assign note_ready_o     = ready_q;
    assign bus_address_o    = addr_q;
    assign bus_data_out_o   = data_q;
    assign bus_read_write_o = rw_q;
    assign bus_clock_o      = bclk_q;
    assign active_mask_o    = active_q;
    assign steal_pulse_o    = steal_q;

endmodule
